fir_mac_decim: RTL and testbench
================================

// Module: fir_mac_decim
// PURPOSE
//  Parametrised, strobe-driven real FIR filter with optional integer decimation, for the 802.11b receive front end.
//  Replaces the fixed 32-tap, fixed-rate correlator: tap count, widths, MAC parallelism and decimation are generic.
//  Samples enter on strobe_in; each output is a rounded, saturated sum of NTAPS products, flagged by strobe_out.
//  Sits between the DDC output and the despreader/correlator chain, one instance per I/Q rail.
// PARAMETERS
//  DW        16  input/output sample width, two's complement
//  CW        16  coefficient width, two's complement
//  NTAPS     32  number of taps; must be a multiple of NMAC
//  NMAC      4   multipliers used per clock; K = NTAPS/NMAC MAC cycles per output
//  DECIM     1   output decimation factor (1 = every sample), 1..16
//  OUT_SHIFT 15  right shift applied to the accumulator before saturation
// PORTS
//  clk          in   1    system clock
//  reset        in   1    asynchronous, active-high reset
//  strobe_in    in   1    indata valid for this clock
//  indata       in   DW   input sample
//  clr_overrun  in   1    synchronous clear of the overrun flag
//  data_out     out  DW   filtered sample, held until the next output
//  strobe_out   out  1    one-clock pulse, data_out valid
//  busy         out  1    MAC sequence in progress
//  overrun      out  1    sticky: a strobe_in arrived while busy
//  coef_we      in   1    [FIR_COEF_LOAD_EN] coefficient write
//  coef_addr    in   clog2(NTAPS)  [FIR_COEF_LOAD_EN] tap index
//  coef_data    in   CW   [FIR_COEF_LOAD_EN] coefficient value
//  coef_ack     out  1    [FIR_COEF_LOAD_EN] one-clock pulse, write accepted
// BEHAVIOUR
//  Reset: data_out=0, strobe_out=0, busy=0, overrun=0, delay line=0, phase=0, FSM=IDLE, coef_ack=0.
//  Delay line: NTAPS x DW; on accepted strobe_in, shift by one with x[0]<=indata. Shifts occur only in IDLE.
//  Phase counter 0..DECIM-1 increments on each accepted strobe_in and wraps; a compute starts on the strobe that wraps it.
//  FSM IDLE -> MAC (K clocks, taps k*NMAC..k*NMAC+NMAC-1 on cycle k) -> ROUND (1 clock) -> IDLE.
//  Accumulator width ACCW = DW+CW+clog2(NTAPS); cleared at MAC entry; products sign-extended to full width.
//  ROUND: add 2^(OUT_SHIFT-1) (skip when OUT_SHIFT=0), arithmetic shift right by OUT_SHIFT, saturate to [-2^(DW-1), 2^(DW-1)-1].
//  Latency: strobe_in at edge T -> strobe_out high during the clock after edge T+K+1 (K+2 clocks). K=8 by default.
//  busy is high from the edge after the starting strobe until strobe_out asserts.
//  strobe_in while busy: sample dropped, delay line and phase unchanged, overrun<=1.
//  overrun clears only on reset or clr_overrun. clr_overrun and a new overrun in the same clock leave overrun=1.
//  Non-compute strobes (DECIM>1) occur only in IDLE; minimum legal strobe spacing is K+2 clocks.
//  Reset asserted mid-sequence aborts at once: no strobe_out, accumulator discarded, all state to reset values.
// CONFIGURATION
//  FIR_COEF_LOAD_EN defined: coefficients in a NTAPS x CW register file, initialised from the package default on reset.
//    coef_we in IDLE writes coef_addr and pulses coef_ack the next clock; coef_we while busy is ignored, no ack.
//    A write and a compute-starting strobe_in in the same clock: the write lands first, and the compute uses the new value.
//  FIR_COEF_LOAD_EN undefined: coefficients are a constant ROM from the package; the coef_* ports are absent.
// STRUCTURE
//  fir_pkg: FIR_DEFAULT_COEF table (32 taps, CW=16), clog2 function, FSM state localparams (IDLE/MAC/ROUND).
//  Sub-module fir_mac_lane: NMAC multipliers plus an adder tree, registered output, instantiated once.
//  Top level holds the delay line, phase counter, FSM, rounding/saturation and overrun logic.
// TESTING  (DW=16, CW=16, NTAPS=8, NMAC=2, OUT_SHIFT=0, coef h[i]=i+1 unless stated)
//  1 Impulse: indata=100 then 0s, strobes 6 clocks apart -> data_out 100,200,...,800, then 0; each strobe_out K+2=6 clocks after its strobe_in.
//  2 Saturation: all h=32767, indata=32767 steady -> data_out=32767; indata=-32768 -> data_out=-32768.
//  3 Rounding: OUT_SHIFT=1, h[0]=1, others 0, indata=3 -> 2; indata=-3 -> -1.
//  4 Overrun: second strobe_in 2 clocks after the first -> overrun=1, sample absent from outputs; clr_overrun -> 0.
//  5 Decimation: DECIM=4, 16 strobes spaced 6 -> exactly 4 strobe_out, on strobes 4,8,12,16.
//  6 Reset mid-MAC: reset during cycle 3 of MAC -> no strobe_out, all outputs 0; next impulse gives case-1 response.
//  7 [FIR_COEF_LOAD_EN] write h[0]=-5 in IDLE -> coef_ack; impulse 10 -> first output -50; write while busy -> no ack.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM encodings, default coefficient table and width helper for fir_mac_decim
package fir_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  // Ramp h[i] = i+1: a known, easily checked response until real taps are loaded.
  localparam logic signed [15:0] FIR_DEFAULT_COEF [32] = '{
    16'sd1,  16'sd2,  16'sd3,  16'sd4,  16'sd5,  16'sd6,  16'sd7,  16'sd8,
    16'sd9,  16'sd10, 16'sd11, 16'sd12, 16'sd13, 16'sd14, 16'sd15, 16'sd16,
    16'sd17, 16'sd18, 16'sd19, 16'sd20, 16'sd21, 16'sd22, 16'sd23, 16'sd24,
    16'sd25, 16'sd26, 16'sd27, 16'sd28, 16'sd29, 16'sd30, 16'sd31, 16'sd32
  };
  // Ceiling log2 with a floor of 1 so that every derived vector has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: NMAC signed multipliers summed into one registered, sign-extended partial sum
// Ports: clk, reset (async, active-high), x[NMAC] samples, h[NMAC] coefficients, y registered sum (OW bits).
module fir_mac_lane #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int NMAC = 4,
  parameter int OW = 37
) (
  input  logic clk,
  input  logic reset,
  input  logic signed [DW-1:0] x [NMAC],
  input  logic signed [CW-1:0] h [NMAC],
  output logic signed [OW-1:0] y
);
  logic signed [DW+CW-1:0] p [NMAC];
  logic signed [OW-1:0] s;
  always_comb begin
    s = '0;
    for (int j = 0; j < NMAC; j++) begin
      p[j] = x[j] * h[j];
      s = s + OW'(p[j]);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) y <= '0;
    else y <= s;
endmodule

// File: rtl/fir_mac_decim.sv
// fir_mac_decim: strobe-driven real FIR with NMAC-wide time-multiplexed MAC, rounding, saturation and decimation
// Ports: clk, reset (async, active-high), strobe_in/indata sample in, clr_overrun, data_out/strobe_out result,
//   busy (MAC sequence running), overrun (sticky dropped-sample flag).
// FIR_COEF_LOAD_EN: adds coef_we/coef_addr/coef_data/coef_ack and a writable coefficient register file;
//   otherwise coefficients are a constant ROM taken from fir_pkg.
module fir_mac_decim
  import fir_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int NTAPS = 32,
  parameter int NMAC = 4,
  parameter int DECIM = 1,
  parameter int OUT_SHIFT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_in,
  input  logic [DW-1:0] indata,
  input  logic clr_overrun,
`ifdef FIR_COEF_LOAD_EN
  input  logic coef_we,
  input  logic [clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic coef_ack,
`endif
  output logic [DW-1:0] data_out,
  output logic strobe_out,
  output logic busy,
  output logic overrun
);
  localparam int K = NTAPS / NMAC;
  localparam int KW = clog2(K);
  localparam int PW = clog2(DECIM);
  localparam int AW = clog2(NTAPS);
  localparam int ACCW = DW + CW + clog2(NTAPS);
  // Half an output LSB; collapses to zero when no shift is applied.
  localparam logic signed [ACCW:0] RND = (ACCW + 1)'(1) << OUT_SHIFT >> 1;
  localparam logic signed [ACCW:0] MAXV = {{(ACCW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = ~MAXV;
  logic [1:0] state, state_nx;
  logic [KW-1:0] k;
  logic [PW-1:0] phase;
  logic signed [DW-1:0] x [NTAPS];
  logic signed [CW-1:0] h [NTAPS];
  logic signed [DW-1:0] lx [NMAC];
  logic signed [CW-1:0] lh [NMAC];
  logic signed [ACCW-1:0] lane_y, acc;
  logic signed [ACCW:0] rsum, shifted;
  logic [DW-1:0] sat;
  logic accept, start, last_k, fire;
  assign accept = strobe_in && state == S_IDLE;
  assign start = accept && phase == PW'(DECIM - 1);
  assign last_k = k == KW'(K - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? (start ? S_MAC : S_IDLE) :
               state == S_MAC ? (last_k ? S_ROUND : S_MAC) : S_IDLE;
  always_comb begin
    busy = state != S_IDLE;
    fire = state == S_ROUND;
  end
`ifdef FIR_COEF_LOAD_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) h[i] <= CW'(FIR_DEFAULT_COEF[i % 32]);
      coef_ack <= 1'b0;
    end else begin
      coef_ack <= coef_we && !busy;
      if (coef_we && !busy) h[coef_addr] <= coef_data;
    end
`else
  always_comb
    for (int i = 0; i < NTAPS; i++) h[i] = CW'(FIR_DEFAULT_COEF[i % 32]);
`endif
  always_comb
    for (int j = 0; j < NMAC; j++) begin
      lx[j] = x[AW'(int'(k) * NMAC + j)];
      lh[j] = h[AW'(int'(k) * NMAC + j)];
    end
  fir_mac_lane #(.DW(DW), .CW(CW), .NMAC(NMAC), .OW(ACCW)) u_lane (
    .clk(clk),
    .reset(reset),
    .x(lx),
    .h(lh),
    .y(lane_y)
  );
  // The lane is registered, so its last partial sum is folded in here during ROUND.
  always_comb begin
    rsum = acc + lane_y + RND;
    shifted = rsum >>> OUT_SHIFT;
    sat = shifted > MAXV ? {1'b0, {(DW - 1){1'b1}}} :
          shifted < MINV ? {1'b1, {(DW - 1){1'b0}}} : shifted[DW-1:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x <= '{default: '0};
      phase <= '0;
      k <= '0;
      acc <= '0;
      data_out <= '0;
      strobe_out <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        x[0] <= indata;
        for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
        phase <= start ? '0 : phase + 1'b1;
      end
      k <= state == S_MAC ? k + 1'b1 : '0;
      // Lane output is stale on the first MAC cycle, so accumulation starts one cycle late.
      acc <= state != S_MAC ? '0 : k == '0 ? acc : acc + lane_y;
      strobe_out <= fire;
      if (fire) data_out <= sat;
      overrun <= (strobe_in && busy) || (overrun && !clr_overrun);
    end
endmodule

// File: tb/tb_fir_mac_decim.sv
// tb_fir_mac_decim: randomized checks of three fir_mac_decim instances against a sum-of-products reference
module tb_fir_mac_decim;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stb [3];
  logic clr [3];
  logic [15:0] din [3];
  logic [15:0] dout [3];
  logic sout [3];
  logic bsy [3];
  logic ovr [3];
`ifdef FIR_COEF_LOAD_EN
  logic cwe = 1'b0;
  logic [2:0] caddr = 3'd0;
  logic [15:0] cdata = 16'd0;
  logic cack [3];
`endif
  int errors = 0;
  int checks = 0;
  int hist [3][8];
  int cf [8];
  int nacc [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fir_mac_decim #(.DW(16), .CW(16), .NTAPS(8), .NMAC(2), .DECIM(g == 2 ? 4 : 1), .OUT_SHIFT(g == 1 ? 1 : 0)) dut (
      .clk(clk),
      .reset(reset),
      .strobe_in(stb[g]),
      .indata(din[g]),
      .clr_overrun(clr[g]),
`ifdef FIR_COEF_LOAD_EN
      .coef_we(g == 0 ? cwe : 1'b0),
      .coef_addr(caddr),
      .coef_data(cdata),
      .coef_ack(cack[g]),
`endif
      .data_out(dout[g]),
      .strobe_out(sout[g]),
      .busy(bsy[g]),
      .overrun(ovr[g])
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 3; u++) begin
      nacc[u] = 0;
      for (int i = 0; i < 8; i++) hist[u][i] = 0;
    end
    for (int i = 0; i < 8; i++) cf[i] = i + 1;
  endfunction

  function automatic void model_push(input int u, input int v);
    for (int i = 7; i > 0; i--) hist[u][i] = hist[u][i-1];
    hist[u][0] = v;
    nacc[u]++;
  endfunction

  function automatic int model_out(input int u, input int sh);
    longint s;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'(hist[u][i]) * longint'(cf[i]);
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    return s > 32767 ? 32767 : s < -32768 ? -32768 : int'(s);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic watch(input int u, input int n0, input int n1, inout int lat, inout int got, inout int cnt);
    for (int n = n0; n <= n1; n++) begin
      if (n > n0) @(negedge clk);
      if (sout[u]) begin
        cnt++;
        if (lat < 0) begin
          lat = n;
          got = sx(dout[u]);
        end
      end
    end
  endtask

  task automatic pulse(input int u, input int v, input int win, output int lat, output int got,
                       output int cnt, output logic b1, output logic bo);
    lat = -1;
    got = 0;
    cnt = 0;
    bo = 1'b1;
    stb[u] = 1'b1;
    din[u] = 16'(v);
    @(negedge clk);
    stb[u] = 1'b0;
    b1 = bsy[u];
    for (int n = 1; n <= win; n++) begin
      if (n > 1) @(negedge clk);
      if (sout[u]) begin
        cnt++;
        if (lat < 0) begin
          lat = n;
          got = sx(dout[u]);
          bo = bsy[u];
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks += 4;
      if (dout[u] !== 16'd0) begin errors++; $display("FAIL reset_dout[%0d]: got %0d want 0", u, dout[u]); end
      if (sout[u] !== 1'b0) begin errors++; $display("FAIL reset_strobe_out[%0d]: got %b want 0", u, sout[u]); end
      if (bsy[u] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", u, bsy[u]); end
      if (ovr[u] !== 1'b0) begin errors++; $display("FAIL reset_overrun[%0d]: got %b want 0", u, ovr[u]); end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_impulse(input string tag);
    int lat, got, cnt, want, v;
    logic b1, bo;
    for (int s = 0; s < 9; s++) begin
      v = s == 0 ? 100 : 0;
      want = s < 8 ? 100 * (s + 1) : 0;
      model_push(0, v);
      pulse(0, v, 6, lat, got, cnt, b1, bo);
      checks += 5;
      if (lat !== 6) begin errors++; $display("FAIL %s_latency[%0d]: got %0d want 6", tag, s, lat); end
      if (got !== want) begin errors++; $display("FAIL %s_data[%0d]: got %0d want %0d", tag, s, got, want); end
      if (cnt !== 1) begin errors++; $display("FAIL %s_count[%0d]: got %0d want 1", tag, s, cnt); end
      if (b1 !== 1'b1) begin errors++; $display("FAIL %s_busy_mac[%0d]: got %b want 1", tag, s, b1); end
      if (bo !== 1'b0) begin errors++; $display("FAIL %s_busy_out[%0d]: got %b want 0", tag, s, bo); end
    end
  endtask

  task automatic test_saturation();
    int lat, got, cnt, want, v, top;
    logic b1, bo;
    top = 0;
    for (int s = 0; s < 16; s++) begin
      v = s < 8 ? 32767 : -32768;
      model_push(0, v);
      want = model_out(0, 0);
      pulse(0, v, 6, lat, got, cnt, b1, bo);
      if (s == 7) top = got;
      checks++;
      if (got !== want) begin errors++; $display("FAIL sat_data[%0d]: got %0d want %0d", s, got, want); end
    end
    checks += 2;
    if (top !== 32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", top); end
    if (got !== -32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", got); end
  endtask

  task automatic test_rounding();
    int lat, got, cnt, want, v;
    logic b1, bo;
    model_push(1, 3);
    pulse(1, 3, 6, lat, got, cnt, b1, bo);
    checks += 2;
    if (got !== 2) begin errors++; $display("FAIL round_pos: got %0d want 2", got); end
    if (lat !== 6) begin errors++; $display("FAIL round_latency: got %0d want 6", lat); end
    do_reset();
    model_push(1, -3);
    pulse(1, -3, 6, lat, got, cnt, b1, bo);
    checks++;
    if (got !== -1) begin errors++; $display("FAIL round_neg: got %0d want -1", got); end
    for (int s = 0; s < 12; s++) begin
      v = rnd16();
      model_push(1, v);
      want = model_out(1, 1);
      pulse(1, v, 6, lat, got, cnt, b1, bo);
      checks++;
      if (got !== want) begin errors++; $display("FAIL round_rand[%0d]: got %0d want %0d", s, got, want); end
    end
  endtask

  task automatic test_overrun();
    int lat, got, cnt, want, v;
    logic b1, bo;
    v = rnd16();
    model_push(0, v);
    want = model_out(0, 0);
    stb[0] = 1'b1;
    din[0] = 16'(v);
    @(negedge clk);
    stb[0] = 1'b0;
    @(negedge clk);
    stb[0] = 1'b1;
    din[0] = 16'(rnd16());
    @(negedge clk);
    stb[0] = 1'b0;
    checks++;
    if (ovr[0] !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", ovr[0]); end
    lat = -1;
    got = 0;
    cnt = 0;
    watch(0, 3, 8, lat, got, cnt);
    checks += 3;
    if (lat !== 6) begin errors++; $display("FAIL overrun_latency: got %0d want 6", lat); end
    if (got !== want) begin errors++; $display("FAIL overrun_data: got %0d want %0d", got, want); end
    if (cnt !== 1) begin errors++; $display("FAIL overrun_count: got %0d want 1", cnt); end
    v = rnd16();
    model_push(0, v);
    want = model_out(0, 0);
    pulse(0, v, 6, lat, got, cnt, b1, bo);
    checks += 2;
    if (got !== want) begin errors++; $display("FAIL overrun_dropped: got %0d want %0d", got, want); end
    if (ovr[0] !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", ovr[0]); end
    v = rnd16();
    model_push(0, v);
    want = model_out(0, 0);
    stb[0] = 1'b1;
    din[0] = 16'(v);
    @(negedge clk);
    din[0] = 16'(rnd16());
    clr[0] = 1'b1;
    @(negedge clk);
    stb[0] = 1'b0;
    clr[0] = 1'b0;
    checks++;
    if (ovr[0] !== 1'b1) begin errors++; $display("FAIL overrun_clr_collide: got %b want 1", ovr[0]); end
    lat = -1;
    got = 0;
    cnt = 0;
    watch(0, 2, 7, lat, got, cnt);
    checks++;
    if (got !== want) begin errors++; $display("FAIL overrun_collide_data: got %0d want %0d", got, want); end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    checks++;
    if (ovr[0] !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", ovr[0]); end
  endtask

  task automatic test_decimation();
    int lat, got, cnt, want, v, nout;
    logic b1, bo;
    nout = 0;
    for (int s = 1; s <= 16; s++) begin
      v = rnd16();
      model_push(2, v);
      want = model_out(2, 0);
      pulse(2, v, 6, lat, got, cnt, b1, bo);
      nout += cnt;
      checks++;
      if (nacc[2] % 4 == 0) begin
        if (cnt !== 1 || got !== want || lat !== 6)
          begin errors++; $display("FAIL decim_out[%0d]: got n=%0d v=%0d lat=%0d want n=1 v=%0d lat=6", s, cnt, got, lat, want); end
      end else if (cnt !== 0) begin
        errors++; $display("FAIL decim_skip[%0d]: got %0d outputs want 0", s, cnt);
      end
    end
    checks++;
    if (nout !== 4) begin errors++; $display("FAIL decim_total: got %0d want 4", nout); end
  endtask

  task automatic test_random();
    int lat, got, cnt, want, v;
    logic b1, bo;
    for (int s = 0; s < 20; s++) begin
      v = rnd16();
      model_push(0, v);
      want = model_out(0, 0);
      pulse(0, v, 6 + $urandom_range(0, 3), lat, got, cnt, b1, bo);
      checks += 2;
      if (got !== want) begin errors++; $display("FAIL rand_data[%0d]: got %0d want %0d", s, got, want); end
      if (lat !== 6) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 6", s, lat); end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    stb[0] = 1'b1;
    din[0] = 16'(rnd16());
    @(negedge clk);
    stb[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks += 4;
    if (dout[0] !== 16'd0) begin errors++; $display("FAIL midreset_dout: got %0d want 0", dout[0]); end
    if (sout[0] !== 1'b0) begin errors++; $display("FAIL midreset_strobe_out: got %b want 0", sout[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bsy[0]); end
    if (ovr[0] !== 1'b0) begin errors++; $display("FAIL midreset_overrun: got %b want 0", ovr[0]); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (sout[0]) cnt++;
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL midreset_no_output: got %0d want 0", cnt); end
    test_impulse("post_reset");
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic test_coef();
    int lat, got, cnt, want;
    logic b1, bo;
    do_reset();
    cwe = 1'b1;
    caddr = 3'd0;
    cdata = 16'hFFFB;
    @(negedge clk);
    cwe = 1'b0;
    cf[0] = -5;
    checks++;
    if (cack[0] !== 1'b1) begin errors++; $display("FAIL coef_ack: got %b want 1", cack[0]); end
    @(negedge clk);
    checks++;
    if (cack[0] !== 1'b0) begin errors++; $display("FAIL coef_ack_pulse: got %b want 0", cack[0]); end
    model_push(0, 10);
    pulse(0, 10, 6, lat, got, cnt, b1, bo);
    checks++;
    if (got !== -50) begin errors++; $display("FAIL coef_impulse: got %0d want -50", got); end
    model_push(0, 0);
    want = model_out(0, 0);
    stb[0] = 1'b1;
    din[0] = 16'd0;
    @(negedge clk);
    stb[0] = 1'b0;
    cwe = 1'b1;
    caddr = 3'd1;
    cdata = 16'd999;
    @(negedge clk);
    cwe = 1'b0;
    checks++;
    if (cack[0] !== 1'b0) begin errors++; $display("FAIL coef_busy_ack: got %b want 0", cack[0]); end
    lat = -1;
    got = 0;
    cnt = 0;
    watch(0, 2, 7, lat, got, cnt);
    checks++;
    if (got !== want) begin errors++; $display("FAIL coef_busy_ignored: got %0d want %0d", got, want); end
    cwe = 1'b1;
    caddr = 3'd2;
    cdata = 16'd7;
    cf[2] = 7;
    model_push(0, 0);
    want = model_out(0, 0);
    pulse(0, 0, 6, lat, got, cnt, b1, bo);
    cwe = 1'b0;
    checks++;
    if (got !== want) begin errors++; $display("FAIL coef_same_clock: got %0d want %0d", got, want); end
  endtask
`endif

  initial begin
    for (int u = 0; u < 3; u++) begin
      stb[u] = 1'b0;
      clr[u] = 1'b0;
      din[u] = 16'd0;
    end
    model_reset();
    test_reset();
    test_impulse("impulse");
    test_saturation();
    test_rounding();
    test_overrun();
    test_decimation();
    test_random();
    test_reset_mid();
`ifdef FIR_COEF_LOAD_EN
    test_coef();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
